mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: cycles in BUSY without mem_ack before abort.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_req  input  1  instruction-fetch request; held high until i_done.
REQ-005 i_addr  input  32  fetch address; stable while i_req high.
REQ-006 d_req  input  1  data request; held high until d_done.
REQ-007 d_we  input  1  data write enable (1 = store, 0 = load).
REQ-008 d_addr  input  32  data address; stable while d_req high.
REQ-009 d_wdata  input  32  store data.
REQ-010 mem_ack  input  1  memory completes current access this cycle.
REQ-011 mem_rdata  input  32  read data, valid with mem_ack.
REQ-012 mem_req  output  1  access active to memory.
REQ-013 mem_we  output  1  write strobe to memory.
REQ-014 mem_addr  output  32  muxed address (d_addr when sel=1, i_addr when sel=0).
REQ-015 mem_wdata  output  32  d_wdata passthrough.
REQ-016 sel  output  1  registered owner select: 1 = data, 0 = instruction.
REQ-017 rdata  output  32  mem_rdata passthrough.
REQ-018 i_done / d_done  output  1 each  one-cycle completion pulse for owner.
REQ-019 i_err / d_err  output  1 each  one-cycle timeout pulse for owner, coincident with done.

Function
REQ-020 FSM states: IDLE, BUSY_I, BUSY_D.
REQ-021 IDLE: i_req only -> BUSY_I; d_req only -> BUSY_D; both -> owner opposite to last_owner; none -> stay.
REQ-022 sel and last_owner update on the IDLE->BUSY edge; sel holds through BUSY.
REQ-023 mem_req = 1 exactly in BUSY_I/BUSY_D; latency request-sampled -> mem_req = 1 cycle.
REQ-024 mem_we = d_we in BUSY_D, 0 otherwise.
REQ-025 done for owner = mem_ack in BUSY state (combinational); next edge -> IDLE.
REQ-026 One IDLE bubble between consecutive transactions; requester drops req on done edge, so no regrant.
REQ-027 wait counter clears on BUSY entry, increments each BUSY cycle without mem_ack.
REQ-028 counter at TIMEOUT-1 without mem_ack: owner done + err pulse, next edge -> IDLE.
REQ-029 mem_ack and timeout in same cycle: ack wins, no err.
REQ-030 mem_ack in IDLE ignored; no done, no state change.
REQ-031 Non-owner requests wait, unaffected, until IDLE.
REQ-032 Counter width ceil(log2(TIMEOUT))+1; no wrap in BUSY.

Reset
REQ-033 rst asserted: state IDLE, sel 0, last_owner instruction (first tie -> data), counter 0, immediately.
REQ-034 Reset mid-transaction: mem_req, mem_we, done, err drop asynchronously; aborted access not completed.
REQ-035 After rst deassertion, arbitration resumes from IDLE on next edge.

Structure
REQ-036 Shared package holds state encoding (IDLE=0, BUSY_I=1, BUSY_D=2), owner constants, default TIMEOUT.
REQ-037 Instantiates one Mux (S=sel, D1=d_addr, D2=i_addr, Y=mem_addr).
REQ-038 Owner/FSM and timeout counter in one always block set; outputs outside FSM combinational.

Verification
REQ-039 i_req=1, i_addr=0x0000_0040, ack 2 cycles after mem_req -> sel=0, mem_addr=0x40, i_done 1 cycle, rdata=mem_rdata=0x0051_3023.
REQ-040 i_req and d_req same cycle after reset -> data first (sel=1, d_addr 0x1000_0000); then instruction; next tie -> data again.
REQ-041 d_req=1, d_we=1, d_wdata=0xDEAD_BEEF, addr 0x2000_0004 -> mem_we=1, mem_wdata=0xDEAD_BEEF, d_done on ack, no i_done.
REQ-042 No mem_ack, TIMEOUT=16 -> i_done and i_err high in 16th BUSY cycle, mem_req low next cycle.
REQ-043 mem_ack in counter=15 cycle -> done, err=0.
REQ-044 rst pulsed during BUSY_D -> mem_req=0 same cycle, sel=0, no d_done; re-request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// state encoding, owner encoding and the default abort timeout.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Two-input word mux: y_o = d1_i when s_i is high, d2_i otherwise.
module mem_port_arbiter_mux #(
  parameter int unsigned W = 32
) (
  input  logic         s_i,
  input  logic [W-1:0] d1_i,
  input  logic [W-1:0] d2_i,
  output logic [W-1:0] y_o
);

  assign y_o = s_i ? d1_i : d2_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access,
// alternating on ties and aborting an access after TIMEOUT cycles without ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        i_done,
  output logic        d_done,
  output logic        i_err,
  output logic        d_err
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic busy;
  logic tmo;
  logic fin;

  assign busy = (state_q != ST_IDLE);
  assign tmo  = (cnt_q == CW'(TIMEOUT - 1));
  // ack takes priority: a timeout coinciding with ack is a normal completion
  assign fin  = busy && (mem_ack || tmo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= OWNER_I;
      last_q  <= OWNER_I;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (d_req && (!i_req || last_q == OWNER_I)) begin
          state_d = ST_BUSY_D;
          sel_d   = OWNER_D;
          last_d  = OWNER_D;
        end else if (i_req) begin
          state_d = ST_BUSY_I;
          sel_d   = OWNER_I;
          last_d  = OWNER_I;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (fin) state_d = ST_IDLE;
        else     cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req   = busy;
  assign mem_we    = (state_q == ST_BUSY_D) && d_we;
  assign mem_wdata = d_wdata;
  assign rdata     = mem_rdata;
  assign sel       = sel_q;

  assign i_done = fin && (state_q == ST_BUSY_I);
  assign d_done = fin && (state_q == ST_BUSY_D);
  assign i_err  = i_done && !mem_ack;
  assign d_err  = d_done && !mem_ack;

  mem_port_arbiter_mux #(.W(32)) u_addr_mux (
    .s_i  (sel_q),
    .d1_i (d_addr),
    .d2_i (i_addr),
    .y_o  (mem_addr)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: a cycle table for
// arbitration/handshake, plus hand sequences for timeout and reset corners.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        mem_req, mem_we, sel, i_done, d_done, i_err, d_err;
  logic [31:0] mem_addr, mem_wdata, rdata;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .sel       (sel),
    .rdata     (rdata),
    .i_done    (i_done),
    .d_done    (d_done),
    .i_err     (i_err),
    .d_err     (d_err)
  );

  typedef struct {
    logic ir, dr, we, ack;
    logic e_req, e_sel, e_we, e_idone, e_ddone;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_sel",     {31'd0, sel},     32'd0);
    chk("rst_done",    {30'd0, i_done, d_done}, 32'd0);
    rst = 1'b0;
  endtask

  // Run an i_req fetch with no ack for ack_at-1 BUSY cycles; ack_at=0 means never ack.
  task automatic timeout_run(input string tag, input int unsigned ack_at);
    i_req = 1'b1;
    tick();
    for (int k = 1; k <= 16; k++) begin
      mem_ack = (k == int'(ack_at));
      #1;
      chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
      if (k < 16 && k != int'(ack_at)) begin
        chk({tag, "_early_done"}, {30'd0, i_done, i_err}, 32'd0);
      end else begin
        chk({tag, "_i_done"}, {31'd0, i_done}, 32'd1);
        chk({tag, "_i_err"},  {31'd0, i_err},  {31'd0, (ack_at == 0)});
        chk({tag, "_d_side"}, {30'd0, d_done, d_err}, 32'd0);
        break;
      end
      tick();
    end
    tick();
    idle_inputs();
    #1;
    chk({tag, "_mem_req_after"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    i_addr = 32'h0000_0040; d_addr = 32'h1000_0000;
    d_wdata = 32'h0; mem_rdata = 32'h0;
    do_reset();

    // ir dr we ack | req sel we idone ddone
    tbl[0]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b1};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[5]  = '{1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b1,1'b0,1'b1};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0};

    foreach (tbl[n]) begin
      i_req = tbl[n].ir; d_req = tbl[n].dr; d_we = tbl[n].we; mem_ack = tbl[n].ack;
      #1;
      chk($sformatf("t%0d_mem_req", n), {31'd0, mem_req}, {31'd0, tbl[n].e_req});
      chk($sformatf("t%0d_sel", n),     {31'd0, sel},     {31'd0, tbl[n].e_sel});
      chk($sformatf("t%0d_mem_we", n),  {31'd0, mem_we},  {31'd0, tbl[n].e_we});
      chk($sformatf("t%0d_mem_addr", n), mem_addr, tbl[n].e_sel ? 32'h1000_0000 : 32'h0000_0040);
      chk($sformatf("t%0d_i_done", n),  {31'd0, i_done},  {31'd0, tbl[n].e_idone});
      chk($sformatf("t%0d_d_done", n),  {31'd0, d_done},  {31'd0, tbl[n].e_ddone});
      chk($sformatf("t%0d_err", n),     {30'd0, i_err, d_err}, 32'd0);
      tick();
    end
    idle_inputs();

    // Fetch with ack two cycles after mem_req rises
    do_reset();
    i_req = 1'b1; mem_rdata = 32'h0051_3023;
    #1;
    chk("f_latency", {31'd0, mem_req}, 32'd0);
    tick();
    chk("f_mem_req", {31'd0, mem_req}, 32'd1);
    chk("f_sel", {31'd0, sel}, 32'd0);
    chk("f_addr", mem_addr, 32'h0000_0040);
    tick();
    chk("f_wait", {31'd0, i_done}, 32'd0);
    tick();
    mem_ack = 1'b1;
    #1;
    chk("f_i_done", {31'd0, i_done}, 32'd1);
    chk("f_rdata", rdata, 32'h0051_3023);
    chk("f_no_err", {31'd0, i_err}, 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("f_idle", {30'd0, mem_req, i_done}, 32'd0);

    // Store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000_0004; d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("s_mem_we", {31'd0, mem_we}, 32'd1);
    chk("s_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("s_addr", mem_addr, 32'h2000_0004);
    chk("s_sel", {31'd0, sel}, 32'd1);
    mem_ack = 1'b1;
    #1;
    chk("s_d_done", {31'd0, d_done}, 32'd1);
    chk("s_no_i_done", {31'd0, i_done}, 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("s_we_drop", {31'd0, mem_we}, 32'd0);
    tick();

    timeout_run("to", 0);
    tick();
    timeout_run("ack15", 16);
    tick();

    // Reset in the middle of a data access
    d_req = 1'b1; d_we = 1'b1;
    tick();
    chk("r_busy", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; rst = 1'b1;
    #1;
    chk("r_mem_req", {31'd0, mem_req}, 32'd0);
    chk("r_mem_we", {31'd0, mem_we}, 32'd0);
    chk("r_sel", {31'd0, sel}, 32'd0);
    chk("r_no_done", {31'd0, d_done}, 32'd0);
    mem_ack = 1'b0; rst = 1'b0;
    tick();
    chk("r_regrant", {31'd0, mem_req}, 32'd1);
    chk("r_regrant_sel", {31'd0, sel}, 32'd1);
    mem_ack = 1'b1;
    #1;
    chk("r_d_done", {31'd0, d_done}, 32'd1);
    tick();
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
